// File: rtl/conv_loader_pkg.sv
// Shared types and size helpers for the conv layer loader.
// Layer sizes are derived here so the top and the sub-module agree on them.
package conv_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_B,
        LOAD_IN,
        KICK,
        WAIT_HI,
        WAIT_LO
    } state_t;

    // Byte index of the final (most significant) byte of a bias word.
    localparam logic [1:0] LAST_BYTE = 2'd3;

    function automatic int w_count(input int oc, input int ic, input int k);
        return oc * ic * k * k;
    endfunction

    function automatic int b_count(input int oc);
        return oc;
    endfunction

    function automatic int in_count(input int ic, input int h, input int w);
        return ic * h * w;
    endfunction

    // Address width for n entries; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bias_word_packer.sv
// Packs four stream bytes, little-endian, into one 32-bit bias word.
// word_valid pulses for one cycle when the fourth byte lands; word holds until the next one.
module bias_word_packer
    import conv_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic [1:0]  byte_idx,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] partial;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_idx   <= '0;
            partial    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
                partial  <= '0;
            end else if (byte_valid) begin
                if (byte_idx == LAST_BYTE) begin
                    word       <= {byte_data, partial};
                    word_valid <= 1'b1;
                    byte_idx   <= '0;
                end else begin
                    case (byte_idx)
                        2'd0:    partial[7:0]   <= byte_data;
                        2'd1:    partial[15:8]  <= byte_data;
                        default: partial[23:16] <= byte_data;
                    endcase
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_layer_loader.sv
// Scatters one byte stream into a conv layer's weight, bias and input write ports,
// then pulses conv_start and waits for a full high-then-low cycle of conv_done.
module conv_layer_loader
    import conv_loader_pkg::*;
#(
    parameter  int INPUT_CHANNELS  = 64,
    parameter  int OUTPUT_CHANNELS = 128,
    parameter  int KERNEL_SIZE     = 3,
    parameter  int INPUT_WIDTH     = 30,
    parameter  int INPUT_HEIGHT    = 30,
    localparam int W_N   = w_count(OUTPUT_CHANNELS, INPUT_CHANNELS, KERNEL_SIZE),
    localparam int B_N   = b_count(OUTPUT_CHANNELS),
    localparam int IN_N  = in_count(INPUT_CHANNELS, INPUT_HEIGHT, INPUT_WIDTH),
    localparam int W_AW  = addr_width(W_N),
    localparam int B_AW  = addr_width(B_N),
    localparam int IN_AW = addr_width(IN_N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run_start,
    input  logic             cfg_load_params,
    output logic             run_busy,
    output logic             run_done,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       weight_data_in,
    output logic             weight_data_we,
    output logic [W_AW-1:0]  weight_data_addr,
    output logic [31:0]      bias_data_in,
    output logic             bias_data_we,
    output logic [B_AW-1:0]  bias_data_addr,
    output logic [7:0]       input_data_in,
    output logic             input_data_we,
    output logic [IN_AW-1:0] input_data_addr,
    output logic             conv_start,
    input  logic             conv_done
);

    localparam logic [W_AW-1:0]  W_LAST  = W_AW'(W_N - 1);
    localparam logic [B_AW-1:0]  B_LAST  = B_AW'(B_N - 1);
    localparam logic [IN_AW-1:0] IN_LAST = IN_AW'(IN_N - 1);

    state_t           state, next_state;
    logic [W_AW-1:0]  w_cnt;
    logic [B_AW-1:0]  b_cnt;
    logic [IN_AW-1:0] in_cnt;
    logic [1:0]       byte_idx;
    logic             xfer;
    logic             start_ok;

    assign xfer     = s_valid & s_ready;
    assign start_ok = run_start & (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        run_busy   = (state != IDLE);
        run_done   = 1'b0;
        case (state)
            IDLE:    if (run_start) next_state = cfg_load_params ? LOAD_W : LOAD_IN;
            LOAD_W: begin
                s_ready = 1'b1;
                if (xfer && w_cnt == W_LAST) next_state = LOAD_B;
            end
            LOAD_B: begin
                s_ready = 1'b1;
                if (xfer && byte_idx == LAST_BYTE && b_cnt == B_LAST) next_state = LOAD_IN;
            end
            LOAD_IN: begin
                s_ready = 1'b1;
                if (xfer && in_cnt == IN_LAST) next_state = KICK;
            end
            KICK:    next_state = WAIT_HI;
            WAIT_HI: if (conv_done) next_state = WAIT_LO;
            WAIT_LO: begin
                if (!conv_done) begin
                    run_done   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Write ports are registered: a transfer at edge n shows we/addr/data from edge n for one cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            weight_data_we   <= 1'b0;
            weight_data_addr <= '0;
            weight_data_in   <= '0;
            bias_data_addr   <= '0;
            input_data_we    <= 1'b0;
            input_data_addr  <= '0;
            input_data_in    <= '0;
            conv_start       <= 1'b0;
            w_cnt            <= '0;
            b_cnt            <= '0;
            in_cnt           <= '0;
        end else begin
            weight_data_we <= 1'b0;
            input_data_we  <= 1'b0;
            conv_start     <= (state == KICK);
            if (start_ok) begin
                w_cnt  <= '0;
                b_cnt  <= '0;
                in_cnt <= '0;
            end
            if (xfer) begin
                case (state)
                    LOAD_W: begin
                        weight_data_we   <= 1'b1;
                        weight_data_addr <= w_cnt;
                        weight_data_in   <= s_data;
                        w_cnt            <= w_cnt + 1'b1;
                    end
                    LOAD_B: begin
                        if (byte_idx == LAST_BYTE) begin
                            bias_data_addr <= b_cnt;
                            b_cnt          <= b_cnt + 1'b1;
                        end
                    end
                    LOAD_IN: begin
                        input_data_we   <= 1'b1;
                        input_data_addr <= in_cnt;
                        input_data_in   <= s_data;
                        in_cnt          <= in_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    bias_word_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (start_ok),
        .byte_data  (s_data),
        .byte_valid (xfer && state == LOAD_B),
        .byte_idx   (byte_idx),
        .word       (bias_data_in),
        .word_valid (bias_data_we)
    );

endmodule

// File: tb/tb_conv_layer_loader.sv
// Bench for conv_layer_loader on a small layer (IC=2 OC=2 K=3 W=H=4).
// A write log is compared against an image built from the stream by plain layout rules.
module tb_conv_layer_loader;

    localparam int IC = 2, OC = 2, K = 3, WD = 4, HT = 4;
    localparam int W_N   = OC * IC * K * K;
    localparam int B_N   = OC;
    localparam int IN_N  = IC * HT * WD;
    localparam int FULL  = W_N + 4 * B_N + IN_N;
    localparam int W_AW  = $clog2(W_N);
    localparam int B_AW  = 1;
    localparam int IN_AW = $clog2(IN_N);
    localparam logic [1:0] P_W = 2'd0, P_B = 2'd1, P_I = 2'd2;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rstn, run_start, cfg_load_params, run_busy, run_done;
    logic [7:0]       s_data;
    logic             s_valid, s_ready;
    logic [7:0]       weight_data_in;
    logic             weight_data_we;
    logic [W_AW-1:0]  weight_data_addr;
    logic [31:0]      bias_data_in;
    logic             bias_data_we;
    logic [B_AW-1:0]  bias_data_addr;
    logic [7:0]       input_data_in;
    logic             input_data_we;
    logic [IN_AW-1:0] input_data_addr;
    logic             conv_start, conv_done;

    int  tests = 0, fails = 0, cyc = 0, last_in_cyc = 0;
    wr_t log_q[$], exp_q[$];
    int  start_q[$], done_q[$];

    conv_layer_loader #(
        .INPUT_CHANNELS(IC), .OUTPUT_CHANNELS(OC), .KERNEL_SIZE(K),
        .INPUT_WIDTH(WD), .INPUT_HEIGHT(HT)
    ) dut (
        .clk(clk), .rstn(rstn), .run_start(run_start), .cfg_load_params(cfg_load_params),
        .run_busy(run_busy), .run_done(run_done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .weight_data_in(weight_data_in), .weight_data_we(weight_data_we), .weight_data_addr(weight_data_addr),
        .bias_data_in(bias_data_in), .bias_data_we(bias_data_we), .bias_data_addr(bias_data_addr),
        .input_data_in(input_data_in), .input_data_we(input_data_we), .input_data_addr(input_data_addr),
        .conv_start(conv_start), .conv_done(conv_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic wr_t mk(input logic [1:0] p, input int a, input logic [31:0] d);
        wr_t e;
        e.port = p;
        e.addr = 32'(a);
        e.data = d;
        return e;
    endfunction

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (weight_data_we) log_q.push_back(mk(P_W, int'(weight_data_addr), 32'(weight_data_in)));
        if (bias_data_we)   log_q.push_back(mk(P_B, int'(bias_data_addr), bias_data_in));
        if (input_data_we) begin
            log_q.push_back(mk(P_I, int'(input_data_addr), 32'(input_data_in)));
            last_in_cyc = cyc;
        end
        if (conv_start) start_q.push_back(cyc);
        if (run_done)   done_q.push_back(cyc);
    end

    // Reference layout: weights byte-per-address, biases little-endian words, then the input map.
    function automatic void build_model(input bit cfg, input byte_q_t b);
        int base = 0;
        exp_q.delete();
        if (cfg) begin
            for (int i = 0; i < W_N; i++) exp_q.push_back(mk(P_W, i, 32'(b[i])));
            for (int j = 0; j < B_N; j++)
                exp_q.push_back(mk(P_B, j, {b[W_N+4*j+3], b[W_N+4*j+2], b[W_N+4*j+1], b[W_N+4*j]}));
            base = W_N + 4 * B_N;
        end
        for (int i = 0; i < IN_N; i++) exp_q.push_back(mk(P_I, i, 32'(b[base+i])));
    endfunction

    task automatic gen_bytes(input int n, input bit rnd, input logic [7:0] first, output byte_q_t q);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(rnd ? 8'($urandom) : 8'(first + 8'(i)));
    endtask

    task automatic clear_logs();
        log_q.delete();
        start_q.delete();
        done_q.delete();
    endtask

    // Tasks begin and end just after a rising edge.
    task automatic start_run(input bit cfg);
        run_start       = 1'b1;
        cfg_load_params = cfg;
        @(posedge clk); #1;
        run_start = 1'b0;
    endtask

    task automatic send_stream(input byte_q_t b, input int pct, input int inject_at);
        int  idx = 0, budget = 0;
        bit  acc, injected = 1'b0;
        while (idx < b.size() && budget < 4000) begin
            s_valid = ($urandom_range(0, 99) < pct);
            s_data  = s_valid ? b[idx] : 8'($urandom);
            if (idx == inject_at && !injected) begin
                run_start       = 1'b1;
                cfg_load_params = 1'b1;
                injected        = 1'b1;
            end
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            run_start = 1'b0;
            if (acc) idx++;
            budget++;
        end
        s_valid = 1'b0;
        if (idx < b.size()) begin
            tests++; fails++;
            $display("FAIL stream stalled: accepted %0d of %0d bytes", idx, b.size());
        end
    endtask

    task automatic finish_run(input int pre, input int hi);
        int b = 0;
        while (start_q.size() == 0 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        tests++;
        if (start_q.size() != 1) begin
            fails++;
            $display("FAIL conv_start pulses: got %0d, expected 1", start_q.size());
        end
        repeat (pre) @(posedge clk);
        #1 conv_done = 1'b1;
        repeat (hi) @(posedge clk);
        #1 conv_done = 1'b0;
        @(negedge clk);
        tests++;
        if (run_done !== 1'b1) begin
            fails++;
            $display("FAIL run_done on conv_done low: got %b, expected 1", run_done);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if ({run_done, run_busy} !== 2'b00) begin
            fails++;
            $display("FAIL after done {run_done,run_busy}: got %b, expected 00", {run_done, run_busy});
        end
        tests++;
        if (done_q.size() != 1) begin
            fails++;
            $display("FAIL run_done pulse count: got %0d, expected 1", done_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; run_start = 1'b1; cfg_load_params = 1'b1; s_valid = 1'b1; s_data = 8'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({weight_data_we, bias_data_we, input_data_we, conv_start, run_done, run_busy, s_ready} !== 7'b0) begin
            fails++;
            $display("FAIL reset flags: got %b, expected 0",
                     {weight_data_we, bias_data_we, input_data_we, conv_start, run_done, run_busy, s_ready});
        end
        tests++;
        if ({weight_data_addr, weight_data_in, bias_data_addr, bias_data_in, input_data_addr, input_data_in} !== '0) begin
            fails++;
            $display("FAIL reset addr/data: got nonzero, expected all 0");
        end
        @(posedge clk); #1;
        rstn = 1'b1; run_start = 1'b0; s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_load();
        byte_q_t b;
        gen_bytes(FULL, 1'b0, 8'h00, b);
        build_model(1'b1, b);
        clear_logs();
        s_valid = 1'b1; s_data = 8'h55;
        repeat (3) @(posedge clk);
        #1 s_valid = 1'b0;
        start_run(1'b1);
        @(negedge clk);
        tests++;
        if ({run_busy, s_ready, log_q.size() == 0} !== 3'b111) begin
            fails++;
            $display("FAIL idle/busy {busy,ready,no_idle_writes}: got %b, expected 111",
                     {run_busy, s_ready, log_q.size() == 0});
        end
        @(posedge clk); #1;
        send_stream(b, 100, -1);
        finish_run(2, 3);
        tests++;
        if (log_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL full_load write count: got %0d, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            tests++;
            if (log_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL full_load write %0d: got p%0d a%0d d%h, expected p%0d a%0d d%h", i,
                         log_q[i].port, log_q[i].addr, log_q[i].data, exp_q[i].port, exp_q[i].addr, exp_q[i].data);
            end
        end
        tests++;
        if (start_q.size() < 1 || start_q[0] != last_in_cyc + 1) begin
            fails++;
            $display("FAIL conv_start timing: got cycle %0d, expected %0d",
                     start_q.size() ? start_q[0] : -1, last_in_cyc + 1);
        end
    endtask

    task automatic test_input_only();
        byte_q_t b;
        int params = 0;
        gen_bytes(IN_N, 1'b0, 8'hA0, b);
        build_model(1'b0, b);
        clear_logs();
        start_run(1'b0);
        send_stream(b, 100, -1);
        finish_run(1, 2);
        foreach (log_q[i]) if (log_q[i].port != P_I) params++;
        tests++;
        if (params != 0) begin
            fails++;
            $display("FAIL input_only weight/bias writes: got %0d, expected 0", params);
        end
        tests++;
        if (log_q.size() == 0 || log_q[0] !== mk(P_I, 0, 32'hA0)) begin
            fails++;
            $display("FAIL input_only first write: got a%0d d%h, expected a0 dA0",
                     log_q.size() ? log_q[0].addr : -1, log_q.size() ? log_q[0].data : 0);
        end
        tests++;
        if (log_q != exp_q) begin
            fails++;
            $display("FAIL input_only image: got %0d writes, expected %0d matching", log_q.size(), exp_q.size());
        end
    endtask

    task automatic test_gappy_stream();
        byte_q_t b;
        gen_bytes(FULL, 1'b0, 8'h00, b);
        build_model(1'b1, b);
        clear_logs();
        start_run(1'b1);
        send_stream(b, 50, -1);
        finish_run(0, 1);
        tests++;
        if (log_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL gappy write count: got %0d, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            tests++;
            if (log_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL gappy write %0d: got p%0d a%0d d%h, expected p%0d a%0d d%h", i,
                         log_q[i].port, log_q[i].addr, log_q[i].data, exp_q[i].port, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_restart_ignored();
        byte_q_t b;
        gen_bytes(IN_N, 1'b0, 8'h60, b);
        build_model(1'b0, b);
        clear_logs();
        start_run(1'b0);
        send_stream(b, 100, 10);
        finish_run(3, 5);
        tests++;
        if (log_q != exp_q) begin
            fails++;
            $display("FAIL restart_ignored image: got %0d writes, expected %0d matching input-only writes",
                     log_q.size(), exp_q.size());
        end
    endtask

    task automatic test_abort_reset();
        byte_q_t b, part;
        gen_bytes(FULL, 1'b1, 8'h00, b);
        part = b[0:W_N+4*B_N+10];
        clear_logs();
        start_run(1'b1);
        send_stream(part, 100, -1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        tests++;
        if ({weight_data_we, bias_data_we, input_data_we, s_ready, run_busy} !== 5'b0) begin
            fails++;
            $display("FAIL abort flags {wwe,bwe,iwe,ready,busy}: got %b, expected 0",
                     {weight_data_we, bias_data_we, input_data_we, s_ready, run_busy});
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (log_q.size() != W_N + B_N + 11 || log_q[$] !== mk(P_I, 10, 32'(b[W_N+4*B_N+10]))) begin
            fails++;
            $display("FAIL abort last write: got %0d writes ending a%0d, expected %0d ending input a10",
                     log_q.size(), log_q.size() ? log_q[$].addr : -1, W_N + B_N + 11);
        end
        build_model(1'b1, b);
        clear_logs();
        start_run(1'b1);
        send_stream(b, 100, -1);
        finish_run(1, 1);
        tests++;
        if (log_q.size() == 0 || log_q[0] !== exp_q[0]) begin
            fails++;
            $display("FAIL abort restart first write: got p%0d a%0d, expected weight a0",
                     log_q.size() ? log_q[0].port : 0, log_q.size() ? log_q[0].addr : -1);
        end
        tests++;
        if (log_q != exp_q) begin
            fails++;
            $display("FAIL abort restart image: got %0d writes, expected %0d matching", log_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random_runs();
        byte_q_t b;
        bit cfg;
        for (int r = 0; r < 4; r++) begin
            cfg = 1'($urandom_range(0, 1));
            gen_bytes(cfg ? FULL : IN_N, 1'b1, 8'h00, b);
            build_model(cfg, b);
            clear_logs();
            start_run(cfg);
            send_stream(b, $urandom_range(20, 100), -1);
            finish_run($urandom_range(0, 4), $urandom_range(1, 6));
            tests++;
            if (log_q != exp_q) begin
                fails++;
                $display("FAIL random run %0d (cfg=%0d) image: got %0d writes, expected %0d matching",
                         r, cfg, log_q.size(), exp_q.size());
            end
        end
    endtask

    initial begin
        rstn = 1'b0; run_start = 1'b0; cfg_load_params = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; conv_done = 1'b0;
        test_reset();
        test_full_load();
        test_input_only();
        test_gappy_stream();
        test_restart_ignored();
        test_abort_reset();
        test_random_runs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
